sprite_pixel_serializer: RTL and testbench



---
 rtl/sprite_pixel_serializer.sv | 141 ++++++++++++++
 tb/tb_sprite_pixel_serializer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_serializer.sv
// sprite_pixel_serializer: serialises 32-bit sprite ROM words into addressed 4-bit pixels, one per clock.
// Define SPRITE_SERIALIZER_CLIP_EN to suppress writes to off-screen addresses (px_addr MSB set).
module sprite_pixel_serializer #(
    parameter int PIXELS_PER_WORD = 8,
    parameter int ADDR_W          = 9
) (
    input  logic                         clk,
    input  logic                         nReset,
    input  logic                         line_start,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [4*PIXELS_PER_WORD-1:0] rom_data,
    input  logic [ADDR_W-1:0]            x_start,
    input  logic                         flip_x,
    output logic                         px_valid,
    output logic [3:0]                   px_data,
    output logic [ADDR_W-1:0]            px_addr,
    output logic                         px_we,
    output logic                         busy
);
    localparam int W = 4 * PIXELS_PER_WORD;

    logic [W-1:0]      a_word_q, a_word_d, h_word_q, h_word_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d, h_x_q, h_x_d;
    logic              a_flip_q, a_flip_d, h_flip_q, h_flip_d;
    logic              a_valid_q, a_valid_d, h_valid_q, h_valid_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              px_valid_q, px_valid_d, px_we_q, px_we_d;
    logic [3:0]        px_data_q, px_data_d;
    logic [ADDR_W-1:0] px_addr_q, px_addr_d;
    logic              accept, last, clip;
    logic [3:0]        pix;
    logic [ADDR_W-1:0] addr;

    assign load_ready = !h_valid_q & !line_start;
    assign busy       = a_valid_q | h_valid_q;
    assign px_valid   = px_valid_q;
    assign px_data    = px_data_q;
    assign px_addr    = px_addr_q;
    assign px_we      = px_we_q;
    assign accept     = load_valid & load_ready;
    assign last       = a_valid_q & (cnt_q == 3'd7);
    // Pixel 0 sits in the top nibble, so unflipped order indexes nibble ~cnt from the bottom
    assign pix        = a_word_q[{(a_flip_q ? cnt_q : ~cnt_q), 2'b00} +: 4];
    assign addr       = a_base_q + ADDR_W'(cnt_q);
`ifdef SPRITE_SERIALIZER_CLIP_EN
    assign clip       = addr[ADDR_W-1];
`else
    assign clip       = 1'b0;
`endif

    always_comb begin
        a_word_d   = a_word_q;
        a_base_d   = a_base_q;
        a_flip_d   = a_flip_q;
        a_valid_d  = a_valid_q;
        h_word_d   = h_word_q;
        h_x_d      = h_x_q;
        h_flip_d   = h_flip_q;
        h_valid_d  = h_valid_q;
        cnt_d      = cnt_q;
        px_valid_d = px_valid_q;
        px_data_d  = px_data_q;
        px_addr_d  = px_addr_q;
        px_we_d    = px_we_q;
        if (line_start) begin
            a_valid_d  = 1'b0;
            h_valid_d  = 1'b0;
            cnt_d      = 3'd0;
            px_valid_d = 1'b0;
            px_we_d    = 1'b0;
        end else if (a_valid_q) begin
            px_valid_d = 1'b1;
            px_data_d  = pix;
            px_addr_d  = addr;
            px_we_d    = (pix != 4'd0) & !clip;
            cnt_d      = cnt_q + 3'd1;
            if (last) begin
                if (h_valid_q) begin
                    a_word_d  = h_word_q;
                    a_base_d  = h_x_q;
                    a_flip_d  = h_flip_q;
                    h_valid_d = 1'b0;
                end else if (accept) begin
                    a_word_d = rom_data;
                    a_base_d = x_start;
                    a_flip_d = flip_x;
                end else begin
                    a_valid_d = 1'b0;
                end
            end else if (accept) begin
                h_word_d  = rom_data;
                h_x_d     = x_start;
                h_flip_d  = flip_x;
                h_valid_d = 1'b1;
            end
        end else begin
            px_valid_d = 1'b0;
            px_we_d    = 1'b0;
            if (accept) begin
                a_word_d  = rom_data;
                a_base_d  = x_start;
                a_flip_d  = flip_x;
                a_valid_d = 1'b1;
                cnt_d     = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            a_word_q   <= '0;
            a_base_q   <= '0;
            a_flip_q   <= 1'b0;
            a_valid_q  <= 1'b0;
            h_word_q   <= '0;
            h_x_q      <= '0;
            h_flip_q   <= 1'b0;
            h_valid_q  <= 1'b0;
            cnt_q      <= 3'd0;
            px_valid_q <= 1'b0;
            px_data_q  <= 4'd0;
            px_addr_q  <= '0;
            px_we_q    <= 1'b0;
        end else begin
            a_word_q   <= a_word_d;
            a_base_q   <= a_base_d;
            a_flip_q   <= a_flip_d;
            a_valid_q  <= a_valid_d;
            h_word_q   <= h_word_d;
            h_x_q      <= h_x_d;
            h_flip_q   <= h_flip_d;
            h_valid_q  <= h_valid_d;
            cnt_q      <= cnt_d;
            px_valid_q <= px_valid_d;
            px_data_q  <= px_data_d;
            px_addr_q  <= px_addr_d;
            px_we_q    <= px_we_d;
        end
    end
endmodule

// File: tb/tb_sprite_pixel_serializer.sv
// tb_sprite_pixel_serializer: directed, table-driven bench for sprite_pixel_serializer.
// Expected write strobes follow SPRITE_SERIALIZER_CLIP_EN when it is defined for the build.
module tb_sprite_pixel_serializer;
    logic        clk = 1'b0;
    logic        nReset, line_start, load_valid, load_ready, flip_x;
    logic [31:0] rom_data;
    logic [8:0]  x_start;
    logic        px_valid, px_we, busy;
    logic [3:0]  px_data;
    logic [8:0]  px_addr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rom;
        logic [8:0]  x;
        logic        flip;
        logic [31:0] seq;
        logic [7:0]  we;
    } vec_t;

    vec_t vecs[5];

    sprite_pixel_serializer dut (
        .clk(clk), .nReset(nReset), .line_start(line_start), .load_valid(load_valid),
        .load_ready(load_ready), .rom_data(rom_data), .x_start(x_start), .flip_x(flip_x),
        .px_valid(px_valid), .px_data(px_data), .px_addr(px_addr), .px_we(px_we), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_word(input vec_t v);
        @(negedge clk);
        rom_data   = v.rom;
        x_start    = v.x;
        flip_x     = v.flip;
        load_valid = 1'b1;
        #1 chk("word_ready", load_ready, 1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("word_latency", px_valid, 0);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] s;
            @(negedge clk);
            s = v.seq >> (28 - 4 * k);
            chk("word_valid", px_valid, 1);
            chk("word_data", px_data, s[3:0]);
            chk("word_addr", px_addr, 9'(v.x + 9'(k)));
            chk("word_we", px_we, v.we[7-k]);
        end
        @(negedge clk);
        chk("word_end_valid", px_valid, 0);
        chk("word_end_busy", busy, 0);
    endtask

    initial begin
        vecs[0] = '{32'h12345678, 9'h010, 1'b0, 32'h12345678, 8'hFF};
        vecs[1] = '{32'h12345678, 9'h010, 1'b1, 32'h87654321, 8'hFF};
        vecs[2] = '{32'h10203040, 9'h020, 1'b0, 32'h10203040, 8'hAA};
`ifdef SPRITE_SERIALIZER_CLIP_EN
        vecs[3] = '{32'h0000000F, 9'h100, 1'b1, 32'hF0000000, 8'h00};
        vecs[4] = '{32'hABCDEF01, 9'h1FC, 1'b0, 32'hABCDEF01, 8'h0D};
`else
        vecs[3] = '{32'h0000000F, 9'h100, 1'b1, 32'hF0000000, 8'h80};
        vecs[4] = '{32'hABCDEF01, 9'h1FC, 1'b0, 32'hABCDEF01, 8'hFD};
`endif
        nReset = 1'b0; line_start = 1'b0; load_valid = 1'b0;
        rom_data = '0; x_start = '0; flip_x = 1'b0;
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
        chk("rst_px_valid", px_valid, 0);
        chk("rst_px_we", px_we, 0);
        chk("rst_px_data", px_data, 0);
        chk("rst_px_addr", px_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", load_ready, 1);

        foreach (vecs[i]) run_word(vecs[i]);

        // Three words with load_valid held: word 3 waits in upstream until H frees
        begin
            logic [31:0] words[3];
            int acc[3];
            int idx = 0, nvalid = 0, first = -1, lastc = -1, pi = 0;
            logic took;
            words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (px_valid) begin
                    nvalid++;
                    if (first < 0) first = c;
                    lastc = c;
                    chk("b2b_data", px_data, 4'((pi / 8) + 1));
                    chk("b2b_addr", px_addr, 9'(pi % 8));
                    pi++;
                end
                if (c == 2) chk("b2b_ready_low", load_ready, 0);
                load_valid = idx < 3;
                if (idx < 3) begin
                    rom_data = words[idx]; x_start = 9'h000; flip_x = 1'b0;
                end
                #1 took = load_valid & load_ready;
                @(posedge clk);
                if (took) begin
                    acc[idx] = c;
                    idx++;
                end
            end
            load_valid = 1'b0;
            chk("b2b_accepted", idx, 3);
            chk("b2b_second_acc", acc[1] - acc[0], 1);
            chk("b2b_third_acc", acc[2] - acc[0], 9);
            chk("b2b_nvalid", nvalid, 24);
            chk("b2b_no_gap", lastc - first + 1, 24);
            chk("b2b_busy_end", busy, 0);
        end

        // line_start on the third pixel with H full and a load pending
        @(negedge clk);
        rom_data = 32'h12345678; x_start = 9'h040; flip_x = 1'b0; load_valid = 1'b1;
        @(negedge clk);
        rom_data = 32'h99999999;
        @(negedge clk);
        rom_data = 32'h77777777;
        @(negedge clk);
        @(negedge clk);
        chk("ls_pix2_data", px_data, 3);
        chk("ls_pix2_addr", px_addr, 9'h042);
        line_start = 1'b1;
        #1 chk("ls_ready_low", load_ready, 0);
        @(negedge clk);
        line_start = 1'b0;
        load_valid = 1'b0;
        chk("ls_px_valid", px_valid, 0);
        chk("ls_px_we", px_we, 0);
        chk("ls_busy", busy, 0);
        repeat (2) @(negedge clk);
        chk("ls_stays_idle", px_valid, 0);
        run_word(vecs[1]);

        // Asynchronous reset in mid-word
        @(negedge clk);
        rom_data = 32'h12345678; x_start = 9'h010; flip_x = 1'b0; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_pre_valid", px_valid, 1);
        #2 nReset = 1'b0;
        #1;
        chk("ar_px_valid", px_valid, 0);
        chk("ar_px_data", px_data, 0);
        chk("ar_px_addr", px_addr, 0);
        chk("ar_busy", busy, 0);
        @(negedge clk);
        nReset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("ar_no_resume", px_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
